// File: rtl/rr_arb_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter family.
// Kept in a package so other arbiters can reuse N_REQ/SEL_W and the state type.
package rr_arb_8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbOwn  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick_8.sv
// Combinational circular priority picker: first set bit of cand scanning upward
// from (last+1) mod 8. Rotate, fixed-priority encode, rotate back.
module rr_pick_8
    import rr_arb_8_pkg::*;
(
    input  logic [N_REQ-1:0] cand_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [N_REQ-1:0] pick_oh_o,
    output logic [SEL_W-1:0] pick_idx_o,
    output logic             any_o
);

    logic [SEL_W:0]       shift;
    logic [2*N_REQ-1:0]   dbl;
    logic [N_REQ-1:0]     rot;
    logic [SEL_W-1:0]     rot_idx;
    logic [SEL_W:0]       sum;

    always_comb begin
        shift = {1'b0, last_i} + (SEL_W + 1)'(1);
        // Doubling the vector turns the rotate into a plain shift; shift of 8 is identity.
        dbl   = {cand_i, cand_i} >> shift;
        rot   = dbl[N_REQ-1:0];

        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = SEL_W'(i);
            end
        end

        sum        = {1'b0, rot_idx} + shift;
        pick_idx_o = sum[SEL_W-1:0];
        any_o      = |cand_i;
        pick_oh_o  = any_o ? (N_REQ'(1) << pick_idx_o) : '0;
    end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for a shared 8:1 mux: registered one-hot grant plus matching
// select. The owner keeps the grant until done, request drop, or hold limit with waiters.
module rr_arb_8
    import rr_arb_8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             valid_o
);

    localparam logic [CNT_W-1:0] HoldLim = CNT_W'(HOLD_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;

    logic             owner_req;
    logic             others_wait;
    logic             at_limit;
    logic             rel;
    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] pick_last;
    logic [N_REQ-1:0] pick_oh;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    assign owner_req   = req_i[sel_q];
    assign others_wait = |(req_i & ~gnt_q);
    assign at_limit    = (hold_cnt_q == HoldLim);
    assign rel         = done_i | ~owner_req | (at_limit & others_wait);

    // While owning, the current owner is excluded and scanning starts just after it.
    assign cand      = (state_q == ArbOwn) ? (req_i & ~gnt_q) : req_i;
    assign pick_last = (state_q == ArbOwn) ? sel_q : last_q;

    rr_pick_8 u_pick (
        .cand_i     (cand),
        .last_i     (pick_last),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;

        unique case (state_q)
            ArbIdle: begin
                if (pick_any) begin
                    state_d    = ArbOwn;
                    gnt_d      = pick_oh;
                    sel_d      = pick_idx;
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ArbOwn: begin
                if (!rel) begin
                    if (!at_limit) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end else if (pick_any) begin
                    gnt_d      = pick_oh;
                    sel_d      = pick_idx;
                    last_d     = sel_q;
                    hold_cnt_d = '0;
                end else if (owner_req && done_i) begin
                    last_d     = sel_q;
                    hold_cnt_d = '0;
                end else begin
                    // sel is left alone so the downstream mux does not toggle while idle.
                    state_d    = ArbIdle;
                    gnt_d      = '0;
                    valid_d    = 1'b0;
                    last_d     = sel_q;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ArbIdle;
            last_q     <= SEL_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_arb_8.sv
// Directed bench for rr_arb_8: scoreboard of expected {gnt,sel,valid} per step,
// plus per-cycle one-hot, sel/gnt agreement and starvation-bound checks.
module tb_rr_arb_8;

    localparam int unsigned HOLD_MAX = 16;

    logic       clk_i;
    logic       rst_n;
    logic [7:0] req_i;
    logic       done_i;
    logic [7:0] gnt_o;
    logic [2:0] sel_o;
    logic       valid_o;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    int   wait_cnt[8];

    rr_arb_8 #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .req_i   (req_i),
        .done_i  (done_i),
        .gnt_o   (gnt_o),
        .sel_o   (sel_o),
        .valid_o (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [2:0] enc(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        n_asserts++;
        assert ({gnt_o, sel_o, valid_o} === {e.gnt, e.sel, e.valid}) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                   e.tag, gnt_o, sel_o, valid_o, e.gnt, e.sel, e.valid);
        end
    endtask

    // Drive one cycle of stimulus, queue what the next edge must produce, then compare.
    task automatic step(input logic [7:0] req, input logic done, input logic [7:0] eg,
                        input logic [2:0] es, input logic ev, input string tag);
        req_i  = req;
        done_i = done;
        sb.push_back('{tag, eg, es, ev});
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    always @(negedge clk_i) begin
        if (rst_n) begin
            n_asserts++;
            assert ($onehot0(gnt_o) && (valid_o === (gnt_o != 8'h00))) else begin
                n_fail++;
                $error("FAIL onehot: observed gnt=%h valid=%b, expected one-hot/zero gnt matching valid",
                       gnt_o, valid_o);
            end
            if (valid_o) begin
                n_asserts++;
                assert (sel_o === enc(gnt_o)) else begin
                    n_fail++;
                    $error("FAIL sel_match: observed sel=%0d, expected %0d", sel_o, enc(gnt_o));
                end
            end
            for (int i = 0; i < 8; i++) begin
                n_asserts++;
                assert (wait_cnt[i] <= 7 * HOLD_MAX) else begin
                    n_fail++;
                    $error("FAIL starve%0d: observed wait=%0d, expected <= %0d",
                           i, wait_cnt[i], 7 * HOLD_MAX);
                end
                wait_cnt[i] <= (req_i[i] && !gnt_o[i]) ? wait_cnt[i] + 1 : 0;
            end
        end else begin
            for (int i = 0; i < 8; i++) wait_cnt[i] <= 0;
        end
    end

    initial begin
        rst_n  = 1'b1;
        req_i  = 8'h00;
        done_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"reset", 8'h00, 3'd0, 1'b0});
        check_out();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;

        // 1: first grant after reset goes to requester 0, one cycle latency
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle_no_req");
        step(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, "first_grant");

        // 2: done hands over back-to-back to requester 7
        step(8'h81, 1'b1, 8'h80, 3'd7, 1'b1, "handover_7");
        step(8'h81, 1'b0, 8'h80, 3'd7, 1'b1, "hold_7");
        step(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, "drop_to_idle");

        // 3: full rotation with done every cycle
        step(8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, "rot_start");
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF, 1'b1, 8'h01 << (k % 8), 3'(k % 8), 1'b1, "rotation");
        end
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "rot_idle");

        // 4: hold limit with a waiter, then unlimited hold when alone
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, "hold_start");
        for (int k = 1; k < 16; k++) begin
            step(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, "holding");
        end
        step(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, "timeout_handover");
        step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, "back_to_0");
        for (int k = 0; k < 40; k++) begin
            step(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, "hold_alone");
        end

        // 5: idle keeps sel; last=3 puts requester 4 ahead
        step(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "owner_3");
        step(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, "idle_sel_3");
        step(8'h18, 1'b0, 8'h10, 3'd4, 1'b1, "pick_after_3");
        step(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, "done_and_drop");

        // Re-grant when alone, then saturated counter releases immediately on a waiter
        step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, "owner_5");
        step(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, "regrant_5");
        for (int k = 0; k < 20; k++) begin
            step(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, "saturate_5");
        end
        step(8'h21, 1'b0, 8'h01, 3'd0, 1'b1, "sat_release");

        // 6: asynchronous reset mid-grant between edges
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{"async_reset", 8'h00, 3'd0, 1'b0});
        check_out();
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        step(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, "post_reset_7");
        step(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, "final_idle");

        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
